// File: rtl/cpu_pkg.sv
// Shared CPU types for the return-address stack: widths, FSM states and fault codes.
package cpu_pkg;

  localparam int unsigned PC_W     = 10;
  localparam int unsigned RS_DEPTH = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } rs_state_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'b00,
    FC_OVERFLOW  = 2'b01,
    FC_UNDERFLOW = 2'b10
  } rs_fault_t;

endpackage

// File: rtl/return_stack_if.sv
// Decoder/PC-side signal bundle for the return stack; master = CPU core, slave = stack.
interface return_stack_if #(
  parameter int unsigned PC_W  = cpu_pkg::PC_W,
  parameter int unsigned DEPTH = cpu_pkg::RS_DEPTH
);
  localparam int unsigned DW = $clog2(DEPTH) + 1;

  logic            start;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] call_target;
  logic [PC_W-1:0] rp;
  logic            jump2sub;
  logic [PC_W-1:0] subroutine;
  logic [DW-1:0]   depth;
  logic            fault;
  logic [1:0]      fault_code;

  modport master (
    output start, call, ret, call_target, rp,
    input  jump2sub, subroutine, depth, fault, fault_code
  );

  modport slave (
    input  start, call, ret, call_target, rp,
    output jump2sub, subroutine, depth, fault, fault_code
  );
endinterface

// File: rtl/rs_regfile.sv
// Return-address storage: one synchronous write port, one combinational read port.
module rs_regfile #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [PC_W-1:0]          wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [PC_W-1:0]          rdata_o
);

  logic [PC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// Subroutine return-address stack with zero-latency jump request and latched overflow/underflow fault.
module return_stack #(
  parameter int unsigned DEPTH = cpu_pkg::RS_DEPTH,
  parameter int unsigned PC_W  = cpu_pkg::PC_W
) (
  input  logic           clk,
  input  logic           reset,
  return_stack_if.slave  bus
);
  import cpu_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  rs_state_t       state_q, state_d;
  rs_fault_t       code_q,  code_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            we_c;
  logic            jump_c;
  logic [PC_W-1:0] sub_c;
  logic [PC_W-1:0] top_c;
  logic [PC_W-1:0] ret_addr_c;
  logic [AW-1:0]   raddr_c;
  logic            empty_c;
  logic            full_c;

  assign empty_c    = (depth_q == '0);
  assign full_c     = (depth_q == DW'(DEPTH));
  assign raddr_c    = AW'(depth_q - DW'(1));
  assign ret_addr_c = bus.rp + PC_W'(1);

  rs_regfile #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_regfile (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (bus.start),
    .we_i    (we_c),
    .waddr_i (depth_q[AW-1:0]),
    .wdata_i (ret_addr_c),
    .raddr_i (raddr_c),
    .rdata_o (top_c)
  );

  // Next state and same-cycle jump request; call wins over a simultaneous ret.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    depth_d = depth_q;
    we_c    = 1'b0;
    jump_c  = 1'b0;
    sub_c   = empty_c ? '0 : top_c;

    if (bus.start) begin
      state_d = RUN;
      code_d  = FC_NONE;
      depth_d = '0;
    end else if (state_q == RUN) begin
      if (bus.call) begin
        if (full_c) begin
          state_d = FAULT;
          code_d  = FC_OVERFLOW;
        end else begin
          we_c    = 1'b1;
          depth_d = depth_q + DW'(1);
          jump_c  = 1'b1;
          sub_c   = bus.call_target;
        end
      end else if (bus.ret) begin
        if (empty_c) begin
          state_d = FAULT;
          code_d  = FC_UNDERFLOW;
        end else begin
          depth_d = depth_q - DW'(1);
          jump_c  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      code_q  <= FC_NONE;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      depth_q <= depth_d;
    end
  end

  // Reset holds the registers at their idle values, so the request must be masked explicitly.
  assign bus.jump2sub   = jump_c & ~reset;
  assign bus.subroutine = sub_c;
  assign bus.depth      = depth_q;
  assign bus.fault      = (state_q == FAULT);
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed plus randomized bench for return_stack, checked against a queue-based stack model.
module tb_return_stack;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TB_PCW = 10;
  localparam int          PC_MOD = 1 << TB_PCW;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  return_stack_if #(.PC_W(TB_PCW), .DEPTH(DEPTH)) bus ();

  return_stack #(.DEPTH(DEPTH), .PC_W(TB_PCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  int m_stack[$];
  bit m_fault;
  int m_code;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_top();
    return (m_stack.size() == 0) ? 0 : m_stack[$];
  endfunction

  task automatic model_clear();
    m_stack.delete();
    m_fault = 1'b0;
    m_code  = 0;
  endtask

  // One clock of stimulus: drive after the falling edge, check before the rising edge, then advance the model.
  task automatic apply(input bit st, input bit c, input bit r, input int tgt, input int pc);
    bit exp_j;
    int exp_sub;
    bit chk_sub;
    @(negedge clk);
    bus.start       = st;
    bus.call        = c;
    bus.ret         = r;
    bus.call_target = TB_PCW'(tgt);
    bus.rp          = TB_PCW'(pc);
    #1;
    check("depth", 32'(bus.depth), m_stack.size());
    check("fault", 32'(bus.fault), int'(m_fault));
    check("fault_code", 32'(bus.fault_code), m_code);

    exp_j   = 1'b0;
    exp_sub = m_top();
    if (!st && !m_fault) begin
      if (c) begin
        if (m_stack.size() < DEPTH) begin
          exp_j   = 1'b1;
          exp_sub = tgt % PC_MOD;
        end
      end else if (r && m_stack.size() > 0) begin
        exp_j = 1'b1;
      end
    end
    chk_sub = exp_j || (!st && !c && !r && !m_fault);
    check("jump2sub", 32'(bus.jump2sub), int'(exp_j));
    if (chk_sub) check("subroutine", 32'(bus.subroutine), exp_sub);

    @(posedge clk);
    if (st) begin
      model_clear();
    end else if (!m_fault) begin
      if (c) begin
        if (m_stack.size() < DEPTH) m_stack.push_back((pc + 1) % PC_MOD);
        else begin m_fault = 1'b1; m_code = 1; end
      end else if (r) begin
        if (m_stack.size() > 0) void'(m_stack.pop_back());
        else begin m_fault = 1'b1; m_code = 2; end
      end
    end
  endtask

  // Asynchronous reset between edges; effect must be visible before the next rising edge.
  task automatic async_reset();
    @(negedge clk);
    bus.call = 1'b1;
    bus.ret  = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_depth", 32'(bus.depth), 0);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_code", 32'(bus.fault_code), 0);
    check("rst_jump", 32'(bus.jump2sub), 0);
    model_clear();
    bus.call  = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.call        = 1'b0;
    bus.ret         = 1'b0;
    bus.call_target = '0;
    bus.rp          = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("init_depth", 32'(bus.depth), 0);
    check("init_fault", 32'(bus.fault), 0);
    check("init_code", 32'(bus.fault_code), 0);
    reset = 1'b0;

    // Single call, then nested calls unwinding in LIFO order.
    apply(0, 1, 0, 'h200, 'h010);
    apply(0, 1, 0, 'h300, 'h205);
    apply(0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 'h301);
    apply(0, 0, 1, 0, 'h207);
    apply(0, 0, 0, 0, 0);

    // Fill, overflow, and confirm fault freezes the stack.
    async_reset();
    for (int i = 0; i < int'(DEPTH); i++) apply(0, 1, 0, 'h100 + i, 'h040 + 4 * i);
    apply(0, 1, 0, 'h3AA, 'h0F0);
    apply(0, 0, 1, 0, 'h0F4);
    apply(0, 0, 0, 0, 0);

    // Underflow, then recovery through start.
    apply(1, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 'h020);
    apply(0, 1, 0, 'h111, 'h022);
    apply(1, 1, 1, 'h123, 'h033);
    apply(0, 1, 0, 'h155, 'h044);
    apply(0, 0, 0, 0, 0);

    // Return-address wrap and call+ret collision.
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 'h050, 'h3FF);
    apply(0, 0, 1, 0, 'h050);
    apply(0, 1, 0, 'h060, 'h010);
    apply(0, 1, 1, 'h070, 'h061);
    apply(0, 0, 0, 0, 0);

    // Mid-sequence asynchronous reset at depth 3.
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 'h080 + i, 'h090 + i);
    async_reset();
    apply(0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 'h010);

    // Randomized traffic, call-heavy first to reach overflow, then balanced.
    for (int phase = 0; phase < 2; phase++) begin
      base = (phase == 0) ? 6 : 4;
      for (int n = 0; n < 300; n++) begin
        int sel;
        bit st, c, r;
        sel = int'($urandom_range(0, 99));
        st  = (sel < 3);
        sel = int'($urandom_range(0, 9));
        c   = (sel < base) || (sel == 9);
        r   = (sel >= base && sel < 9) || (sel == 9);
        apply(st, c, r, int'($urandom_range(0, PC_MOD - 1)), int'($urandom_range(0, PC_MOD - 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of return-address entries (power of two, 2..16).
REQ-002 Parameter PC_W, default 10, program-counter width in bits.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-005 start  input  1  synchronous clear of stack and fault while high (same meaning as the CPU start line).
REQ-006 call  input  1  decoded subroutine-call instruction in the current cycle.
REQ-007 ret  input  1  decoded subroutine-return instruction in the current cycle.
REQ-008 call_target  input  PC_W  absolute subroutine entry address for call.
REQ-009 rp  input  PC_W  current program-counter value (address of the call/ret instruction).
REQ-010 jump2sub  output  1  request to the program counter to load subroutine this cycle.
REQ-011 subroutine  output  PC_W  address the program counter loads when jump2sub is high.
REQ-012 depth  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 fault  output  1  stack fault latched (overflow or underflow).
REQ-014 fault_code  output  2  00 none, 01 overflow, 10 underflow.

Function
REQ-015 jump2sub and subroutine SHALL be combinational from call, ret, state and top-of-stack, so the program counter loads on the same clock edge that updates the stack (zero-cycle latency).
REQ-016 State machine SHALL have two states: RUN and FAULT.
REQ-017 RUN, call, depth<DEPTH: push (rp+1) mod 2^PC_W, depth+1, jump2sub=1, subroutine=call_target.
REQ-018 RUN, ret, depth>0: pop, depth-1, jump2sub=1, subroutine=top entry.
REQ-019 call and ret both high SHALL be treated as call only; ret ignored that cycle.
REQ-020 RUN, call, depth==DEPTH: no write, jump2sub=0, next state FAULT, fault_code=01.
REQ-021 RUN, ret, depth==0: no pop, jump2sub=0, next state FAULT, fault_code=10.
REQ-022 FAULT: call/ret ignored, jump2sub=0, depth and entries frozen, fault=1, until start or reset.
REQ-023 Neither call nor ret: jump2sub=0, subroutine=top entry (or 0 when empty), no state change.
REQ-024 Return address SHALL wrap: rp=10'h3FF pushes 10'h000.
REQ-025 Top entry SHALL be the most recently pushed; entries below top are never modified by a push.

Reset
REQ-026 reset high SHALL asynchronously force state RUN, depth=0, fault=0, fault_code=00, all entries 0; jump2sub=0 while reset high.
REQ-027 start high SHALL, at the next clock edge, give the same values as reset and suppress jump2sub; it overrides call/ret.
REQ-028 Reset asserted mid-sequence SHALL discard all pushed addresses; no partial pop.

Structure
REQ-029 Package cpu_pkg SHALL hold PC_W, RS_DEPTH, the rs_state_t enum (RUN, FAULT) and the rs_fault_t fault-code enum.
REQ-030 Entry storage SHALL be a sub-module rs_regfile (DEPTH x PC_W, one write port, one combinational read port at index depth-1).
REQ-031 Control, pointer arithmetic and FSM SHALL live in return_stack; no other sub-modules.

Verification
REQ-032 Reset, then call with rp=10'h010, call_target=10'h200 -> jump2sub=1, subroutine=10'h200; next cycle depth=1.
REQ-033 Nested calls at rp=10'h010, then rp=10'h205 -> two rets return 10'h206, then 10'h011; depth 2->1->0.
REQ-034 DEPTH calls, then a ninth call -> jump2sub=0, fault=1, fault_code=01, depth stays 8; a subsequent ret is ignored.
REQ-035 ret with depth=0 -> jump2sub=0, fault_code=10; start pulse -> depth=0, fault=0, and the next call succeeds.
REQ-036 call with rp=10'h3FF, then ret -> subroutine=10'h000; same-cycle call+ret at depth 1 -> push only, depth=2.
REQ-037 Assert reset asynchronously between clock edges at depth=3 -> depth=0 and fault=0 immediately, before the next edge.
